uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter write port (d_in/wr_en/tx_full) between NUM_REQ byte-stream requesters.
//  Round-robin arbitration; a grant is held for a whole packet (until req_last), bounded by MAX_BURST bytes.
//  Sits between on-chip message sources and the UART TX FIFO; the TX FIFO and serializer are unchanged.
// PARAMETERS
//  NUM_REQ    4   number of requester ports (2..8)
//  DATA_W     8   byte width; must match UART TX d_in
//  MAX_BURST  16  max bytes per grant before forced release; 0 = unlimited (packet-atomic only)
// PORTS
//  clk        in   1                 system clock, all logic on posedge
//  reset      in   1                 asynchronous, active-high reset
//  req_valid  in   NUM_REQ           per-requester byte valid
//  req_data   in   NUM_REQ*DATA_W    per-requester byte, requester i at [i*DATA_W +: DATA_W]
//  req_last   in   NUM_REQ           byte is last of packet (qualified by valid&ready)
//  req_ready  out  NUM_REQ           byte accepted this cycle (one-hot or zero)
//  d_in       out  DATA_W            byte to UART TX FIFO
//  wr_en      out  1                 UART TX FIFO write strobe
//  tx_full    in   1                 UART TX FIFO full
//  grant_id   out  $clog2(NUM_REQ)   index of current owner (valid while busy)
//  busy       out  1                 a requester holds the grant
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0, wr_en=0, d_in=0, grant_id=0, busy=0, burst_cnt=0, rr_ptr=NUM_REQ-1.
//  FSM, two states:
//   IDLE:   if |req_valid -> grant_id<=picked index, rr_ptr<=picked, burst_cnt<=0, ->LOCKED. No byte moves in IDLE.
//   LOCKED: accept = req_valid[grant_id] & ~tx_full. On accept: burst_cnt++.
//           -> IDLE when accept & (req_last[grant_id] | (MAX_BURST!=0 & burst_cnt==MAX_BURST-1)).
//  Pick: first requester with req_valid in order rr_ptr+1, rr_ptr+2, ... wrapping modulo NUM_REQ.
//  Handshake (combinational, zero latency): req_ready[grant_id]=accept in LOCKED, all others 0;
//   wr_en=accept; d_in=req_data[grant_id] when LOCKED else 0. No byte is ever written while tx_full=1.
//  Grant->first byte latency: 1 cycle (IDLE cycle to grant, byte may transfer in next cycle).
//  Release->next grant: always one IDLE cycle between packets (max throughput 1 byte/clk within packet).
//  Owner drops req_valid mid-packet: grant held, no bytes written, no timeout.
//  tx_full high in LOCKED: stall, state and burst_cnt hold; no req_ready.
//  Forced release at MAX_BURST: remaining bytes of that packet re-arbitrate normally (may interleave).
//  req_valid of non-owners ignored while LOCKED; req_last of non-accepted beats ignored.
//  busy = (state==LOCKED); grant_id holds last owner in IDLE.
//  Reset mid-packet: immediate return to reset values; partial packet already in FIFO is not recalled.
// STRUCTURE
//  Package uart_tx_arb_pkg: typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t; ARB_ID_W function/localparam helpers.
//  Sub-module uart_rr_picker (combinational): inputs req vector + rr_ptr, outputs picked index + any_req.
//  Top holds FSM, grant_id/rr_ptr/burst_cnt registers and the output mux.
// TESTING
//  1) Single requester 0 sends 3 bytes 0xA1,0xA2,0xA3(last), tx_full=0 -> wr_en 3 consecutive cycles
//     after 1-cycle grant, d_in in order, busy drops the cycle after 0xA3.
//  2) Req 0..3 all valid with 1-byte packets from reset -> grant order 0,1,2,3,0; one IDLE cycle between each.
//  3) tx_full asserted for 5 cycles mid-packet on req 2 -> no wr_en, no req_ready during stall;
//     bytes resume in order, none lost or duplicated.
//  4) MAX_BURST=4, req 1 sends 6-byte packet while req 3 waits -> 4 bytes from 1, then req 3's packet,
//     then remaining 2 bytes from 1.
//  5) Assert reset while LOCKED with 2 bytes pending -> same cycle: wr_en=0, req_ready=0, busy=0;
//     after release req 0 wins first.
//  6) Owner drops req_valid for 3 cycles mid-packet while req 0 valid -> grant retained, req 0 never ready
//     until owner's last byte.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_arb_pkg
// Shared types and width helpers for the UART TX write-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE / LOCKED)
//   arb_id_w    : width of a requester index for a given requester count
//   arb_cnt_w   : width of the per-grant byte counter for a given burst limit
// ----------------------------------------------------------------------------
package uart_tx_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int ARB_NUM_REQ_MIN = 2;
  localparam int ARB_NUM_REQ_MAX = 8;

  function automatic int arb_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // The counter only has to reach MAX_BURST-1; with no limit it just wraps.
  function automatic int arb_cnt_w(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// ----------------------------------------------------------------------------
// uart_rr_picker
// Combinational round-robin pick: first set bit of req, searching from
// rr_ptr+1 upward and wrapping modulo NUM_REQ (rr_ptr itself is tried last).
// Ports:
//   req     in  NUM_REQ  request vector
//   rr_ptr  in  ID_W     index of the most recent winner
//   pick    out ID_W     winning index (0 when any_req=0)
//   any_req out 1        at least one request present
// ----------------------------------------------------------------------------
module uart_rr_picker
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = arb_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    pick,
  output logic               any_req
);

  always_comb begin
    logic [ID_W-1:0] idx;
    idx     = '0;
    pick    = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(rr_ptr) + 32'(k)) % 32'(NUM_REQ));
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares the UART TX FIFO write port between NUM_REQ byte-stream requesters.
// Round-robin grant, held for a whole packet (until req_last) or until
// MAX_BURST bytes have moved (0 = no limit). One IDLE cycle separates grants.
// Ports:
//   clk        in   1                system clock
//   reset      in   1                asynchronous active-high reset
//   req_valid  in   NUM_REQ          per-requester byte valid
//   req_data   in   NUM_REQ*DATA_W   requester i at [i*DATA_W +: DATA_W]
//   req_last   in   NUM_REQ          last byte of packet (on accepted beats)
//   req_ready  out  NUM_REQ          byte accepted this cycle (one-hot/zero)
//   d_in       out  DATA_W           byte to UART TX FIFO
//   wr_en      out  1                UART TX FIFO write strobe
//   tx_full    in   1                UART TX FIFO full
//   grant_id   out  $clog2(NUM_REQ)  current / most recent owner
//   busy       out  1                a requester holds the grant
//
// state      | meaning
// ARB_IDLE   | no owner; pick next requester, no byte moves
// ARB_LOCKED | grant_id owns the port; bytes pass when valid & ~tx_full
// ----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]            d_in,
  output logic                         wr_en,
  input  logic                         tx_full,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = arb_cnt_w(MAX_BURST);

  localparam logic [CNT_W-1:0] BURST_TC = CNT_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
  // Reset pointer makes requester 0 the first winner after reset.
  localparam logic [ID_W-1:0]  RR_RST   = ID_W'(NUM_REQ - 1);

  arb_state_t         state, state_next;
  logic [ID_W-1:0]    grant_id_next;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_next;
  logic [CNT_W-1:0]   burst_cnt, burst_cnt_next;
  logic [ID_W-1:0]    pick;
  logic               any_req;
  logic               accept;
  logic               burst_done;
  logic               owner_valid;
  logic               owner_last;
  logic [DATA_W-1:0]  owner_data;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .pick    (pick),
    .any_req (any_req)
  );

  assign owner_valid = req_valid[grant_id];
  assign owner_last  = req_last[grant_id];
  assign owner_data  = req_data[grant_id*DATA_W +: DATA_W];
  assign busy        = (state == ARB_LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      grant_id  <= '0;
      rr_ptr    <= RR_RST;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      grant_id  <= grant_id_next;
      rr_ptr    <= rr_ptr_next;
      burst_cnt <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    grant_id_next  = grant_id;
    rr_ptr_next    = rr_ptr;
    burst_cnt_next = burst_cnt;
    accept         = 1'b0;
    burst_done     = 1'b0;
    req_ready      = '0;
    wr_en          = 1'b0;
    d_in           = '0;

    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          state_next     = ARB_LOCKED;
          grant_id_next  = pick;
          rr_ptr_next    = pick;
          burst_cnt_next = '0;
        end
      end

      ARB_LOCKED: begin
        d_in       = owner_data;
        // Non-owner valids and an idle owner simply leave the grant parked.
        accept     = owner_valid & ~tx_full;
        burst_done = (MAX_BURST != 0) && (burst_cnt == BURST_TC);
        if (accept) begin
          req_ready[grant_id] = 1'b1;
          wr_en               = 1'b1;
          burst_cnt_next      = burst_cnt + 1'b1;
          if (owner_last || burst_done) begin
            state_next = ARB_IDLE;
          end
        end
      end

      default: state_next = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_last = '0;
  logic [NR-1:0]     req_ready;
  logic [DW-1:0]     d_in;
  logic              wr_en;
  logic              tx_full = 1'b0;
  logic [IW-1:0]     grant_id;
  logic              busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .d_in      (d_in),
    .wr_en     (wr_en),
    .tx_full   (tx_full),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = nobody), last winner, bytes in grant.
  int m_owner, m_gid, m_last, m_cnt;

  logic          o_busy, o_wr;
  logic [IW-1:0] o_gid;
  logic [DW-1:0] o_d;
  logic [NR-1:0] o_ready;

  logic [8:0] src_q [NR][$];
  int         log_q[$];
  int         exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_gid   = 0;
    m_last  = NR - 1;
    m_cnt   = 0;
  endfunction

  // Called at a negedge; drives inputs, checks outputs, advances one clock.
  task automatic step(input logic [NR-1:0] v, input logic [NR*DW-1:0] d,
                      input logic [NR-1:0] l, input logic f);
    logic          acc;
    logic [NR-1:0] e_ready;
    logic [DW-1:0] e_d;
    req_valid = v;
    req_data  = d;
    req_last  = l;
    tx_full   = f;
    #1;
    o_busy  = busy;
    o_wr    = wr_en;
    o_gid   = grant_id;
    o_d     = d_in;
    o_ready = req_ready;
    acc     = 1'b0;
    e_ready = '0;
    e_d     = '0;
    if (m_owner >= 0) begin
      acc = v[m_owner] && !f;
      e_d = d[m_owner*DW +: DW];
      if (acc) e_ready[m_owner] = 1'b1;
    end
    chk("busy", o_busy, m_owner >= 0);
    chk("grant_id", o_gid, m_gid);
    chk("wr_en", o_wr, acc);
    chk("d_in", o_d, e_d);
    chk("req_ready", o_ready, e_ready);
    if (o_wr) log_q.push_back(int'(o_gid) * 256 + int'(o_d));
    @(posedge clk);
    if (m_owner < 0) begin
      if (|v) begin
        for (int k = 1; k <= NR; k++) begin
          if (v[(m_last + k) % NR]) begin
            m_owner = (m_last + k) % NR;
            break;
          end
        end
        m_gid  = m_owner;
        m_last = m_owner;
        m_cnt  = 0;
      end
    end else if (acc) begin
      m_cnt++;
      if (l[m_owner] || (MB != 0 && m_cnt == MB)) m_owner = -1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '1;
    req_last  = '1;
    req_data  = '1;
    tx_full   = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_ready", req_ready, '0);
    chk("rst_d_in", d_in, '0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_grant_id", grant_id, '0);
    chk("rst_busy_hold", busy, 1'b0);
    reset = 1'b0;
    model_reset();
    log_q.delete();
    exp_q.delete();
    for (int i = 0; i < NR; i++) src_q[i].delete();
  endtask

  task automatic push_pkt(input int id, input int n, input int base);
    for (int j = 0; j < n; j++) src_q[id].push_back({(j == n - 1), 8'(base + j)});
  endtask

  task automatic run_src(input int max_cyc, input int full_from, input int full_len);
    logic [NR-1:0]    v, l;
    logic [NR*DW-1:0] d;
    logic             f;
    int               pending;
    for (int c = 0; c < max_cyc; c++) begin
      pending = 0;
      for (int i = 0; i < NR; i++) pending += src_q[i].size();
      if (pending == 0) break;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < NR; i++) begin
        if (src_q[i].size() > 0) begin
          v[i]          = 1'b1;
          d[i*DW +: DW] = src_q[i][0][7:0];
          l[i]          = src_q[i][0][8];
        end
      end
      f = (c >= full_from) && (c < full_from + full_len);
      step(v, d, l, f);
      if (f) begin
        chk("stall_wr_en", o_wr, 1'b0);
        chk("stall_ready", o_ready, '0);
      end
      for (int i = 0; i < NR; i++) if (o_ready[i]) void'(src_q[i].pop_front());
    end
    pending = 0;
    for (int i = 0; i < NR; i++) pending += src_q[i].size();
    chk("drain_timeout", pending, 0);
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < log_q.size()) ? log_q[i] : -1, exp_q[i]);
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // 1) single requester, three-byte packet
    do_reset();
    step(4'b0001, 32'h0000_00A1, 4'b0000, 1'b0);
    chk("t1_grant_cycle_wr", o_wr, 1'b0);
    step(4'b0001, 32'h0000_00A1, 4'b0000, 1'b0);
    chk("t1_b0", {o_wr, o_d}, 9'h1A1);
    step(4'b0001, 32'h0000_00A2, 4'b0000, 1'b0);
    chk("t1_b1", {o_wr, o_d}, 9'h1A2);
    step(4'b0001, 32'h0000_00A3, 4'b0001, 1'b0);
    chk("t1_b2", {o_wr, o_d}, 9'h1A3);
    step(4'b0000, 32'h0, 4'b0000, 1'b0);
    chk("t1_busy_drop", o_busy, 1'b0);

    // 2) everyone requesting single-byte packets
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(4'hF, 32'h1312_1110, 4'hF, 1'b0);
      if (k % 2 == 0) begin
        chk("t2_gap_wr", o_wr, 1'b0);
      end else begin
        chk("t2_order_gid", o_gid, (k / 2) % NR);
        chk("t2_order_d", o_d, 8'h10 + (k / 2) % NR);
      end
    end

    // 3) tx_full stall in the middle of requester 2's packet
    do_reset();
    push_pkt(2, 4, 8'hB0);
    run_src(40, 3, 5);
    for (int j = 0; j < 4; j++) exp_q.push_back(2 * 256 + 8'hB0 + j);
    chk_log("t3_log");

    // 4) burst limit splits requester 1's packet around requester 3
    do_reset();
    push_pkt(1, 6, 8'hC0);
    push_pkt(3, 2, 8'hD0);
    run_src(60, 1000, 0);
    for (int j = 0; j < 4; j++) exp_q.push_back(1 * 256 + 8'hC0 + j);
    exp_q.push_back(3 * 256 + 8'hD0);
    exp_q.push_back(3 * 256 + 8'hD1);
    exp_q.push_back(1 * 256 + 8'hC4);
    exp_q.push_back(1 * 256 + 8'hC5);
    chk_log("t4_log");

    // 5) reset while locked with bytes still pending
    do_reset();
    step(4'b0010, 32'h0000_E000, 4'b0000, 1'b0);
    step(4'b0010, 32'h0000_E000, 4'b0000, 1'b0);
    step(4'b0010, 32'h0000_E100, 4'b0000, 1'b0);
    chk("t5_locked_before", o_busy, 1'b1);
    req_valid = 4'b0010;
    req_data  = 32'h0000_E200;
    reset     = 1'b1;
    #1;
    chk("t5_wr_en", wr_en, 1'b0);
    chk("t5_ready", req_ready, '0);
    chk("t5_busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(4'b0101, 32'h0055_0044, 4'b0101, 1'b0);
    step(4'b0101, 32'h0055_0044, 4'b0101, 1'b0);
    chk("t5_first_gid", o_gid, 0);
    chk("t5_first_ready", o_ready, 4'b0001);

    // 6) owner goes quiet mid-packet while requester 0 waits
    do_reset();
    step(4'b0100, 32'h0060_0000, 4'b0000, 1'b0);
    step(4'b0100, 32'h0060_0000, 4'b0000, 1'b0);
    chk("t6_first_wr", o_wr, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 32'h0000_0007, 4'b0001, 1'b0);
      chk("t6_hold_ready", o_ready, '0);
      chk("t6_hold_gid", {o_busy, o_gid}, 3'b110);
    end
    step(4'b0101, 32'h0061_0007, 4'b0100, 1'b0);
    chk("t6_last_ready", o_ready, 4'b0100);
    step(4'b0001, 32'h0000_0007, 4'b0001, 1'b0);
    chk("t6_gap", o_busy, 1'b0);
    step(4'b0001, 32'h0000_0007, 4'b0001, 1'b0);
    chk("t6_req0_ready", o_ready, 4'b0001);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step(4'($urandom), $urandom, 4'($urandom) & 4'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
